mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the core's single memory port between the fetch unit (instruction reads) and the load/store path (requests flagged by decode via memory_request / memory_request_type). Grants one requester at a time and registers its request onto the memory bus. Tracks a single outstanding transaction and routes the memory response back to its owner. Sits between the fetch/execute stages and the memory interface.

Parameters:
ADDR_WIDTH, 32, address width of all request ports
DATA_WIDTH, 32, data width of all data ports
STARVE_LIMIT, 4, consecutive data grants made while fetch is waiting, after which fetch wins the next arbitration (≥1)

Ports:
clk  in  1  core clock, rising edge
reset_n  in  1  asynchronous active-low reset
imem_req_valid  in  1  fetch request pending
imem_req_addr  in  ADDR_WIDTH  fetch address
imem_req_ready  out  1  fetch request accepted this cycle
imem_resp_valid  out  1  fetch data valid, one-cycle pulse
imem_resp_data  out  DATA_WIDTH  fetched instruction word
dmem_req_valid  in  1  load/store request pending
dmem_req_type  in  1  MEM_REQ_READ / MEM_REQ_WRITE
dmem_req_addr  in  ADDR_WIDTH  data address
dmem_req_wdata  in  DATA_WIDTH  store data
dmem_req_wmask  in  DATA_WIDTH/8  store byte enables
dmem_req_ready  out  1  data request accepted this cycle
dmem_resp_valid  out  1  load data / store ack, one-cycle pulse
dmem_resp_data  out  DATA_WIDTH  load data (0 on store ack)
mem_req_valid  out  1  request to memory
mem_req_type  out  1  MEM_REQ_READ / MEM_REQ_WRITE
mem_req_addr  out  ADDR_WIDTH  registered address
mem_req_wdata  out  DATA_WIDTH  registered store data
mem_req_wmask  out  DATA_WIDTH/8  registered byte enables (0 for reads)
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  memory response; one per accepted request, reads and writes
mem_resp_data  in  DATA_WIDTH  read data
proto_err  out  1  sticky: mem_resp_valid seen outside WAIT

Behaviour:
- Reset (async, reset_n=0): state IDLE, owner cleared, starve counter 0, proto_err 0, every registered output 0, all ready/valid outputs 0. An in-flight transaction is dropped with no response; requesters reissue.
- FSM states: IDLE, ISSUE, WAIT. Owner register: FETCH or DATA.
- IDLE: grant is combinational. If both valid: DATA wins, unless starve_cnt == STARVE_LIMIT, in which case FETCH wins. Else any single valid requester wins. The granted *_req_ready is 1 for exactly that cycle. Latch addr/type/wdata/wmask (fetch: type READ, wmask 0) and the owner -> ISSUE. No valid requester: stay in IDLE.
- Starve counter: increments on a DATA grant while imem_req_valid=1, saturating at STARVE_LIMIT. Clears on any FETCH grant, or on a DATA grant with imem_req_valid=0.
- ISSUE: mem_req_valid=1 with registered fields, held stable until mem_req_ready=1 -> WAIT. Latency from accept to mem_req_valid is 1 cycle.
- WAIT: mem_req_valid=0. On mem_resp_valid: owner's *_resp_valid=1 for that cycle; data passes combinationally from mem_resp_data (dmem_resp_data forced 0 for writes); -> IDLE. The next grant is possible the following cycle.
- A response in the same cycle as mem_req_ready is not allowed: the earliest response is the cycle after acceptance.
- mem_resp_valid in IDLE or ISSUE: ignored, no *_resp_valid, proto_err set to 1 until reset.
- *_req_ready is never 1 outside IDLE. At most one *_req_ready and at most one *_resp_valid is high per cycle.
- Requester valid may drop without acceptance; no state change results.

Decomposition:
- MEM_REQ_READ / MEM_REQ_WRITE and new ARB_OWNER_FETCH / ARB_OWNER_DATA and ARB_IDLE / ARB_ISSUE / ARB_WAIT encodings go in consts.vh.
- One sub-module is natural: mem_arb_grant (combinational priority + starvation counter), instantiated by mem_arbiter.

Test Plan:
- Reset: hold reset_n=0 with random inputs, then also assert it mid-WAIT -> all outputs 0, state IDLE, proto_err 0; no late imem/dmem_resp_valid after release.
- Fetch read: imem_req addr 0x100 at c0 -> imem_req_ready c0, mem_req_valid/addr 0x100/type READ c1; mem_req_ready c1, mem_resp_valid c3 data 0xDEADBEEF -> imem_resp_valid c3 with 0xDEADBEEF.
- Contention: both valid at c0, STARVE_LIMIT=4 -> dmem granted c0; imem granted in first IDLE after the dmem response.
- Starvation: dmem_req_valid and imem_req_valid held high, STARVE_LIMIT=4 -> grants D,D,D,D,F,D... counter resets after F.
- Store: type WRITE, addr 0x2000, wdata 0x12345678, wmask 0xF -> mem_req_type WRITE, mem_req_wmask 0xF; ack -> dmem_resp_valid with data 0.
- Spurious: mem_resp_valid in IDLE -> proto_err 1 and sticky, no resp pulses; mem_req_ready low 5 cycles -> request fields held stable.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: request types, owner and FSM states.
package mem_arbiter_pkg;

  localparam logic MEM_REQ_READ  = 1'b0;
  localparam logic MEM_REQ_WRITE = 1'b1;

  typedef enum logic {
    ARB_OWNER_FETCH = 1'b0,
    ARB_OWNER_DATA  = 1'b1
  } arb_owner_e;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational fetch/data priority with a saturating counter that lets a waiting
// fetch win once it has been passed over STARVE_LIMIT times in a row.
module mem_arb_grant
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_arb_en,
  input  logic       i_fetch_valid,
  input  logic       i_data_valid,
  output logic       o_grant_fetch,
  output logic       o_grant_data,
  output arb_owner_e o_owner
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved     = (r_starve_cnt == LIMIT);
  assign o_grant_fetch = i_arb_en & i_fetch_valid & (~i_data_valid | w_starved);
  assign o_grant_data  = i_arb_en & i_data_valid & ~o_grant_fetch;
  assign o_owner       = o_grant_data ? ARB_OWNER_DATA : ARB_OWNER_FETCH;

  // Counts only data grants that actually bypassed a waiting fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
    end else if (o_grant_fetch) begin
      r_starve_cnt <= '0;
    end else if (o_grant_data) begin
      if (!i_fetch_valid) begin
        r_starve_cnt <= '0;
      end else if (!w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch and load/store: grants in IDLE, presents the
// registered request in ISSUE, and routes the single outstanding response in WAIT.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    imem_req_valid,
  input  logic [ADDR_WIDTH-1:0]   imem_req_addr,
  output logic                    imem_req_ready,
  output logic                    imem_resp_valid,
  output logic [DATA_WIDTH-1:0]   imem_resp_data,
  input  logic                    dmem_req_valid,
  input  logic                    dmem_req_type,
  input  logic [ADDR_WIDTH-1:0]   dmem_req_addr,
  input  logic [DATA_WIDTH-1:0]   dmem_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] dmem_req_wmask,
  output logic                    dmem_req_ready,
  output logic                    dmem_resp_valid,
  output logic [DATA_WIDTH-1:0]   dmem_resp_data,
  output logic                    mem_req_valid,
  output logic                    mem_req_type,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    proto_err
);

  arb_state_e                r_state;
  arb_state_e                w_state_nxt;
  arb_owner_e                r_owner;
  arb_owner_e                w_grant_owner;
  logic                      r_req_type;
  logic [ADDR_WIDTH-1:0]     r_req_addr;
  logic [DATA_WIDTH-1:0]     r_req_wdata;
  logic [DATA_WIDTH/8-1:0]   r_req_wmask;
  logic                      r_proto_err;
  logic                      w_arb_en;
  logic                      w_grant_fetch;
  logic                      w_grant_data;
  logic                      w_grant;

  // Gating with reset_n keeps the readies low while reset is held, not just after it.
  assign w_arb_en = reset_n & (r_state == ARB_IDLE);
  assign w_grant  = w_grant_fetch | w_grant_data;

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_grant (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_arb_en      (w_arb_en),
    .i_fetch_valid (imem_req_valid),
    .i_data_valid  (dmem_req_valid),
    .o_grant_fetch (w_grant_fetch),
    .o_grant_data  (w_grant_data),
    .o_owner       (w_grant_owner)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    imem_req_ready  = w_grant_fetch;
    dmem_req_ready  = w_grant_data;
    mem_req_valid   = 1'b0;
    imem_resp_valid = 1'b0;
    dmem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    dmem_resp_data  = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_grant) w_state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (mem_resp_valid) begin
          w_state_nxt = ARB_IDLE;
          if (r_owner == ARB_OWNER_DATA) begin
            dmem_resp_valid = 1'b1;
            dmem_resp_data  = (r_req_type == MEM_REQ_WRITE) ? '0 : mem_resp_data;
          end else begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_resp_data;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Request fields are captured only at grant so they stay stable through ISSUE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner     <= ARB_OWNER_FETCH;
      r_req_type  <= MEM_REQ_READ;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_req_wmask <= '0;
    end else if (w_grant) begin
      r_owner <= w_grant_owner;
      if (w_grant_data) begin
        r_req_type  <= dmem_req_type;
        r_req_addr  <= dmem_req_addr;
        r_req_wdata <= dmem_req_wdata;
        r_req_wmask <= (dmem_req_type == MEM_REQ_WRITE) ? dmem_req_wmask : '0;
      end else begin
        r_req_type  <= MEM_REQ_READ;
        r_req_addr  <= imem_req_addr;
        r_req_wdata <= '0;
        r_req_wmask <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_proto_err <= 1'b0;
    end else if (mem_resp_valid && (r_state != ARB_WAIT)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign mem_req_type  = r_req_type;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_wdata = r_req_wdata;
  assign mem_req_wmask = r_req_wmask;
  assign proto_err     = r_proto_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int MW    = DW / 8;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          dmem_req_valid;
  logic          dmem_req_type;
  logic [AW-1:0] dmem_req_addr;
  logic [DW-1:0] dmem_req_wdata;
  logic [MW-1:0] dmem_req_wmask;
  logic          dmem_req_ready;
  logic          dmem_resp_valid;
  logic [DW-1:0] dmem_resp_data;
  logic          mem_req_valid;
  logic          mem_req_type;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [MW-1:0] mem_req_wmask;
  logic          mem_req_ready;
  logic          mem_resp_valid;
  logic [DW-1:0] mem_resp_data;
  logic          proto_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: one pending transaction, whether memory took it, starvation tally.
  bit            m_busy;
  bit            m_issued;
  bit            m_err;
  bit            m_data_own;
  bit            m_type;
  int            m_starve;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [MW-1:0] m_wmask;
  byte           g_hist[$];

  mem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_type   (dmem_req_type),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_wmask  (dmem_req_wmask),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_data  (dmem_resp_data),
    .mem_req_valid   (mem_req_valid),
    .mem_req_type    (mem_req_type),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_wmask   (mem_req_wmask),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .proto_err       (proto_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_issued = 1'b0; m_err = 1'b0; m_data_own = 1'b0;
    m_type = MEM_REQ_READ; m_starve = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
  endtask

  task automatic clear_inputs();
    imem_req_valid = 1'b0; imem_req_addr = '0;
    dmem_req_valid = 1'b0; dmem_req_type = MEM_REQ_READ; dmem_req_addr = '0;
    dmem_req_wdata = '0; dmem_req_wmask = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
  endtask

  task automatic rand_requesters();
    imem_req_valid = 1'($urandom_range(0, 1));
    imem_req_addr  = $urandom;
    dmem_req_valid = 1'($urandom_range(0, 1));
    dmem_req_type  = 1'($urandom_range(0, 1));
    dmem_req_addr  = $urandom;
    dmem_req_wdata = $urandom;
    dmem_req_wmask = MW'($urandom);
  endtask

  // Well-behaved memory: accepts at once, answers as soon as it may.
  task automatic auto_mem();
    mem_req_ready  = 1'b1;
    mem_resp_valid = m_busy && m_issued;
    mem_resp_data  = $urandom;
  endtask

  function automatic void predict_grant(output bit fw, output bit dw);
    fw = 1'b0;
    dw = 1'b0;
    if (!m_busy) begin
      fw = imem_req_valid && (!dmem_req_valid || (m_starve == LIMIT));
      dw = dmem_req_valid && !fw;
    end
  endfunction

  task automatic settle();
    bit fw, dw, ir, dr;
    @(negedge clk);
    if (!reset_n) begin
      chk1("rst_imem_req_ready", imem_req_ready, 1'b0);
      chk1("rst_dmem_req_ready", dmem_req_ready, 1'b0);
      chk1("rst_imem_resp_valid", imem_resp_valid, 1'b0);
      chk1("rst_dmem_resp_valid", dmem_resp_valid, 1'b0);
      chk32("rst_imem_resp_data", imem_resp_data, 32'h0);
      chk32("rst_dmem_resp_data", dmem_resp_data, 32'h0);
      chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
      chk1("rst_mem_req_type", mem_req_type, 1'b0);
      chk32("rst_mem_req_addr", mem_req_addr, 32'h0);
      chk32("rst_mem_req_wdata", mem_req_wdata, 32'h0);
      chk32("rst_mem_req_wmask", 32'(mem_req_wmask), 32'h0);
      chk1("rst_proto_err", proto_err, 1'b0);
      return;
    end
    predict_grant(fw, dw);
    ir = m_busy && m_issued && mem_resp_valid && !m_data_own;
    dr = m_busy && m_issued && mem_resp_valid && m_data_own;
    chk1("imem_req_ready", imem_req_ready, fw);
    chk1("dmem_req_ready", dmem_req_ready, dw);
    chk1("mem_req_valid", mem_req_valid, m_busy && !m_issued);
    if (m_busy && !m_issued) begin
      chk1("mem_req_type", mem_req_type, m_type);
      chk32("mem_req_addr", mem_req_addr, m_addr);
      chk32("mem_req_wmask", 32'(mem_req_wmask), 32'(m_wmask));
      if (m_data_own) chk32("mem_req_wdata", mem_req_wdata, m_wdata);
    end
    chk1("imem_resp_valid", imem_resp_valid, ir);
    chk1("dmem_resp_valid", dmem_resp_valid, dr);
    if (ir) chk32("imem_resp_data", imem_resp_data, mem_resp_data);
    if (dr) chk32("dmem_resp_data", dmem_resp_data,
                  (m_type == MEM_REQ_WRITE) ? 32'h0 : mem_resp_data);
    chk1("proto_err", proto_err, m_err);
  endtask

  task automatic tick();
    bit fw, dw, waiting;
    predict_grant(fw, dw);
    waiting = m_busy && m_issued;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
      #1;
      return;
    end
    if (mem_resp_valid && !waiting) m_err = 1'b1;
    if (!m_busy) begin
      if (fw || dw) begin
        g_hist.push_back(dw ? "D" : "F");
        m_busy     = 1'b1;
        m_issued   = 1'b0;
        m_data_own = dw;
        if (fw) begin
          m_type = MEM_REQ_READ; m_addr = imem_req_addr; m_wdata = '0; m_wmask = '0;
          m_starve = 0;
        end else begin
          m_type  = dmem_req_type;
          m_addr  = dmem_req_addr;
          m_wdata = dmem_req_wdata;
          m_wmask = (dmem_req_type == MEM_REQ_WRITE) ? dmem_req_wmask : '0;
          m_starve = imem_req_valid ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        end
      end
    end else if (!m_issued) begin
      if (mem_req_ready) m_issued = 1'b1;
    end else if (mem_resp_valid) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    for (int c = 0; c < 20 && m_busy; c++) begin
      auto_mem(); settle(); tick();
    end
    clear_inputs();
  endtask

  initial begin
    string pat;
    reset_n = 1'b0;
    clear_inputs();
    model_reset();

    // Reset held with random activity on every input.
    for (int i = 0; i < 4; i++) begin
      rand_requesters();
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data = $urandom;
      settle(); tick();
    end
    clear_inputs();
    reset_n = 1'b1;

    // Fetch read.
    imem_req_valid = 1'b1; imem_req_addr = 32'h100;
    settle(); chk1("fetch_c0_ready", imem_req_ready, 1'b1); tick();
    imem_req_valid = 1'b0; mem_req_ready = 1'b1;
    settle();
    chk1("fetch_c1_valid", mem_req_valid, 1'b1);
    chk32("fetch_c1_addr", mem_req_addr, 32'h100);
    chk1("fetch_c1_type", mem_req_type, MEM_REQ_READ);
    tick();
    mem_req_ready = 1'b0;
    settle(); tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    settle();
    chk1("fetch_c3_resp_valid", imem_resp_valid, 1'b1);
    chk32("fetch_c3_resp_data", imem_resp_data, 32'hDEADBEEF);
    tick();
    clear_inputs();

    // Store with memory stalling for five cycles.
    dmem_req_valid = 1'b1; dmem_req_type = MEM_REQ_WRITE; dmem_req_addr = 32'h2000;
    dmem_req_wdata = 32'h12345678; dmem_req_wmask = 4'hF;
    settle(); chk1("store_ready", dmem_req_ready, 1'b1); tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk1("store_hold_type", mem_req_type, MEM_REQ_WRITE);
      chk32("store_hold_addr", mem_req_addr, 32'h2000);
      chk32("store_hold_wdata", mem_req_wdata, 32'h12345678);
      chk32("store_hold_wmask", 32'(mem_req_wmask), 32'hF);
      tick();
    end
    mem_req_ready = 1'b1;
    settle(); tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A55A5A;
    settle();
    chk1("store_ack_valid", dmem_resp_valid, 1'b1);
    chk32("store_ack_data", dmem_resp_data, 32'h0);
    tick();
    clear_inputs();

    // Contention: data first, the waiting fetch next.
    g_hist.delete();
    imem_req_valid = 1'b1; imem_req_addr = 32'h300;
    dmem_req_valid = 1'b1; dmem_req_type = MEM_REQ_READ; dmem_req_addr = 32'h400;
    for (int c = 0; c < 30 && g_hist.size() < 2; c++) begin
      auto_mem(); settle(); tick();
      if (g_hist.size() >= 1) dmem_req_valid = 1'b0;
    end
    chk32("contention_grant_count", 32'(g_hist.size()), 32'd2);
    pat = "DF";
    for (int i = 0; i < 2; i++)
      chk32($sformatf("contention_grant%0d", i), 32'(g_hist[i]), 32'(pat[i]));
    drain();

    // Starvation: both held, fetch wins after LIMIT data grants.
    g_hist.delete();
    imem_req_valid = 1'b1; imem_req_addr = 32'h500;
    dmem_req_valid = 1'b1; dmem_req_type = MEM_REQ_READ; dmem_req_addr = 32'h600;
    for (int c = 0; c < 60 && g_hist.size() < 6; c++) begin
      auto_mem(); settle(); tick();
    end
    chk32("starve_grant_count", 32'(g_hist.size()), 32'd6);
    pat = "DDDDFD";
    for (int i = 0; i < 6; i++)
      chk32($sformatf("starve_grant%0d", i), 32'(g_hist[i]), 32'(pat[i]));
    drain();

    // Randomized traffic with a cooperative but irregular memory.
    for (int c = 0; c < 400; c++) begin
      rand_requesters();
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_valid = m_busy && m_issued && ($urandom_range(0, 2) == 0);
      mem_resp_data  = $urandom;
      settle(); tick();
    end
    drain();

    // Spurious responses in IDLE and in ISSUE.
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD0BAD;
    settle();
    chk1("spur_idle_no_iresp", imem_resp_valid, 1'b0);
    chk1("spur_idle_no_dresp", dmem_resp_valid, 1'b0);
    tick();
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle(); chk1("spur_sticky", proto_err, 1'b1); tick();
    end
    imem_req_valid = 1'b1; imem_req_addr = 32'h700;
    settle(); tick();
    imem_req_valid = 1'b0; mem_resp_valid = 1'b1;
    settle(); chk1("spur_issue_no_iresp", imem_resp_valid, 1'b0); tick();
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    settle(); tick();
    mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h13572468;
    settle(); chk1("spur_then_resp", imem_resp_valid, 1'b1); tick();
    clear_inputs();

    // Reset asserted mid-WAIT drops the transaction.
    dmem_req_valid = 1'b1; dmem_req_type = MEM_REQ_READ; dmem_req_addr = 32'h800;
    settle(); tick();
    clear_inputs(); mem_req_ready = 1'b1;
    settle(); tick();
    rand_requesters();
    mem_resp_valid = 1'b1; mem_resp_data = $urandom;
    reset_n = 1'b0;
    #1;
    chk1("midreset_proto_err", proto_err, 1'b0);
    chk1("midreset_dresp", dmem_resp_valid, 1'b0);
    settle(); tick();
    clear_inputs();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk1("post_reset_no_iresp", imem_resp_valid, 1'b0);
      chk1("post_reset_no_dresp", dmem_resp_valid, 1'b0);
      tick();
    end
    imem_req_valid = 1'b1; imem_req_addr = 32'h900;
    settle(); chk1("post_reset_grant", imem_req_ready, 1'b1); tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
